// File: rtl/ppi_pattern_generator.sv
// PPI test-pattern source for the ToF capture path: configurable frame geometry,
// four pattern modes, multi-frame or continuous runs with graceful stop.
module ppi_pattern_generator #(
   parameter int unsigned       DATA_W       = 16,
   parameter int unsigned       FRAME_WIDTH  = 162,
   parameter int unsigned       FRAME_HEIGHT = 120,
   parameter int unsigned       HBI          = 10,
   parameter int unsigned       VBI          = 2,
   parameter logic [DATA_W-1:0] NO_DATA      = '1
) (
   input  logic              clk_ppi,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [7:0]        num_frames,
   input  logic [1:0]        mode,
   output logic              ready,
   output logic              busy,
   output logic              frame_done,
   output logic [DATA_W-1:0] ppi_data,
   output logic              ppi_fs1,
   output logic              ppi_fs2,
   output logic              ppi_fs3
);

   localparam logic [15:0] W_LAST   = 16'(FRAME_WIDTH - 1);
   localparam logic [15:0] H_LAST   = 16'(FRAME_HEIGHT - 1);
   localparam logic [15:0] HBI_LAST = 16'(HBI - 1);
   localparam logic [15:0] VBI_LAST = 16'(VBI - 1);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_w_q, cnt_w_d;
   logic [15:0] cnt_h_q, cnt_h_d;
   logic [15:0] cnt_b_q, cnt_b_d;
   logic [7:0]  frames_left_q, frames_left_d;
   logic [7:0]  run_frames_q;
   logic        start_q;
   logic        stop_pending_q;
   logic [1:0]  mode_q;
   logic [15:0] lfsr_q, lfsr_next;
   logic        accept;
   logic        frame_start;
   logic        last_frame;
   logic [31:0] pix_full;

   // Accepted start is held one cycle so pixel (0,0) lands two edges after it.
   assign accept     = start & ready & (state_q == StIdle) & ~start_q;
   assign last_frame = stop_pending_q | (stop & busy) |
                       ((run_frames_q != 8'd0) && (frames_left_q == 8'd1));
   assign lfsr_next  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

   always_comb begin
      state_d       = state_q;
      cnt_w_d       = cnt_w_q;
      cnt_h_d       = cnt_h_q;
      cnt_b_d       = cnt_b_q;
      frames_left_d = frames_left_q;
      frame_start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_q) begin
               state_d     = StActive;
               cnt_w_d     = '0;
               cnt_h_d     = '0;
               frame_start = 1'b1;
            end
         end
         StActive: begin
            if (cnt_w_q == W_LAST) begin
               state_d = StHblank;
               cnt_b_d = '0;
            end else begin
               cnt_w_d = cnt_w_q + 16'd1;
            end
         end
         StHblank: begin
            if (cnt_b_q != HBI_LAST) begin
               cnt_b_d = cnt_b_q + 16'd1;
            end else if (cnt_h_q == H_LAST) begin
               state_d = StVblank;
               cnt_b_d = '0;
            end else begin
               state_d = StActive;
               cnt_w_d = '0;
               cnt_h_d = cnt_h_q + 16'd1;
            end
         end
         StVblank: begin
            if (cnt_b_q != VBI_LAST) begin
               cnt_b_d = cnt_b_q + 16'd1;
            end else if (last_frame) begin
               state_d = StIdle;
            end else begin
               if (run_frames_q != 8'd0) frames_left_d = frames_left_q - 8'd1;
               state_d     = StActive;
               cnt_w_d     = '0;
               cnt_h_d     = '0;
               frame_start = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_ppi) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_w_q        <= '0;
         cnt_h_q        <= '0;
         cnt_b_q        <= '0;
         frames_left_q  <= '0;
         run_frames_q   <= '0;
         start_q        <= 1'b0;
         stop_pending_q <= 1'b0;
         mode_q         <= '0;
         lfsr_q         <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         cnt_w_q <= cnt_w_d;
         cnt_h_q <= cnt_h_d;
         cnt_b_q <= cnt_b_d;
         start_q <= accept;
         if (accept) begin
            frames_left_q <= num_frames;
            run_frames_q  <= num_frames;
         end else begin
            frames_left_q <= frames_left_d;
         end
         if (state_q == StIdle) stop_pending_q <= 1'b0;
         else if (stop && busy) stop_pending_q <= 1'b1;
         if (frame_start) begin
            mode_q <= mode;
            lfsr_q <= LFSR_SEED;
         end else if (state_q == StActive) begin
            lfsr_q <= lfsr_next;
         end
      end
   end

   always_comb begin
      case (mode_q)
         2'd0:    pix_full = 32'(cnt_h_q) * FRAME_WIDTH + 32'(cnt_w_q);
         2'd1:    pix_full = 32'(cnt_w_q);
         2'd2:    pix_full = 32'(cnt_h_q);
         default: pix_full = 32'(lfsr_q);
      endcase
   end

   // Output stage trails the state register by one cycle.
   always_ff @(posedge clk_ppi) begin
      if (rst) begin
         ready      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         ppi_data   <= NO_DATA;
         ppi_fs1    <= 1'b0;
         ppi_fs2    <= 1'b0;
         ppi_fs3    <= 1'b0;
      end else begin
         ready      <= (state_q == StIdle);
         busy       <= (state_q != StIdle);
         frame_done <= (state_q == StVblank) && (cnt_b_q == 16'd0);
         ppi_data   <= (state_q == StActive) ? DATA_W'(pix_full) : NO_DATA;
         ppi_fs1    <= (state_q == StActive);
         ppi_fs2    <= (state_q == StActive) || (state_q == StHblank);
         ppi_fs3    <= (state_q == StActive) && (cnt_w_q == 16'd0) && (cnt_h_q == 16'd0);
      end
   end

endmodule

// File: tb/tb_ppi_pattern_generator.sv
// Randomized bench for ppi_pattern_generator against a frame-level reference model
// that builds each expected frame as a queue of output beats.
module tb_ppi_pattern_generator;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 5;
   localparam int unsigned HB = 3;
   localparam int unsigned VB = 2;

   typedef struct packed {
      logic [15:0] data;
      logic        fs1;
      logic        fs2;
      logic        fs3;
      logic        done;
   } beat_t;

   logic        clk_ppi = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [7:0]  num_frames = 8'd0;
   logic [1:0]  mode = 2'd0;
   logic        ready, busy, frame_done, ppi_fs1, ppi_fs2, ppi_fs3;
   logic [15:0] ppi_data;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          chk_en = 1'b0;

   ppi_pattern_generator #(
      .DATA_W       (16),
      .FRAME_WIDTH  (W),
      .FRAME_HEIGHT (H),
      .HBI          (HB),
      .VBI          (VB)
   ) dut (
      .clk_ppi    (clk_ppi),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .num_frames (num_frames),
      .mode       (mode),
      .ready      (ready),
      .busy       (busy),
      .frame_done (frame_done),
      .ppi_data   (ppi_data),
      .ppi_fs1    (ppi_fs1),
      .ppi_fs2    (ppi_fs2),
      .ppi_fs3    (ppi_fs3)
   );

   always #5 clk_ppi = ~clk_ppi;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: whole frames are appended to a beat queue at frame start.
   beat_t       q[$];
   beat_t       exp_beat;
   logic        exp_ready, exp_busy;
   bit          in_run, launch, stop_req;
   int unsigned run_frames, frames_out;
   localparam beat_t IDLE_BEAT = '{data: 16'hFFFF, fs1: 1'b0, fs2: 1'b0, fs3: 1'b0, done: 1'b0};

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   task automatic gen_frame(input logic [1:0] md);
      logic [15:0] l = 16'hACE1;
      beat_t b;
      for (int h = 0; h < H; h++) begin
         for (int w = 0; w < W; w++) begin
            case (md)
               2'd0:    b.data = 16'(h * W + w);
               2'd1:    b.data = 16'(w);
               2'd2:    b.data = 16'(h);
               default: b.data = l;
            endcase
            l = lfsr_step(l);
            b.fs1 = 1'b1; b.fs2 = 1'b1; b.fs3 = (h == 0 && w == 0); b.done = 1'b0;
            q.push_back(b);
         end
         for (int k = 0; k < HB; k++) begin
            b = IDLE_BEAT; b.fs2 = 1'b1;
            q.push_back(b);
         end
      end
      for (int k = 0; k < VB; k++) begin
         b = IDLE_BEAT; b.done = (k == 0);
         q.push_back(b);
      end
      frames_out++;
   endtask

   always @(posedge clk_ppi) begin
      logic busy_prev, ready_prev;
      if (rst) begin
         q.delete();
         in_run = 0; launch = 0; stop_req = 0;
         exp_beat = IDLE_BEAT; exp_ready = 1'b0; exp_busy = 1'b0;
      end else begin
         busy_prev  = exp_busy;
         ready_prev = exp_ready;
         exp_ready  = !in_run;
         exp_busy   = in_run;
         if (stop && busy_prev && in_run) stop_req = 1;
         exp_beat = (q.size() != 0) ? q.pop_front() : IDLE_BEAT;
         if (launch) begin
            launch = 0; in_run = 1; frames_out = 0;
            gen_frame(mode);
         end else if (in_run && q.size() == 0) begin
            if (stop_req || (run_frames != 0 && frames_out == run_frames)) begin
               in_run = 0; stop_req = 0;
            end else begin
               gen_frame(mode);
            end
         end else if (start && ready_prev && !in_run) begin
            launch = 1; run_frames = num_frames;
         end
      end
   end

   always @(negedge clk_ppi) begin
      if (chk_en)
         check("beat", {ready, busy, frame_done, ppi_fs3, ppi_fs2, ppi_fs1, ppi_data},
               {exp_ready, exp_busy, exp_beat.done, exp_beat.fs3, exp_beat.fs2,
                exp_beat.fs1, exp_beat.data});
   end

   task automatic step();
      @(posedge clk_ppi);
      #2;
   endtask

   task automatic wait_fs3(input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk_ppi);
         if (ppi_fs3) begin
            ok = 1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      repeat (3) step();
      @(negedge clk_ppi);
      check("rst_outputs", {ready, busy, frame_done, ppi_fs1, ppi_fs2, ppi_fs3, ppi_data},
            {6'b0, 16'hFFFF});
      step();
      rst = 1'b0;
      chk_en = 1'b1;
      step();
      @(negedge clk_ppi);
      check("ready_after_rst", ready, 1'b1);

      // Directed LFSR run: two frames, both seeded identically.
      step();
      mode = 2'd3; num_frames = 8'd2; start = 1'b1;
      step();
      start = 1'b0;
      wait_fs3(10, ok);
      check("fs3_seen", ok, 1'b1);
      check("lfsr_px0", ppi_data, 16'hACE1);
      @(negedge clk_ppi);
      check("lfsr_px1", ppi_data, 16'hE270);
      @(negedge clk_ppi);
      check("lfsr_px2", ppi_data, 16'h7138);
      wait_fs3(200, ok);
      check("fs3_frame2", ok, 1'b1);
      check("lfsr_f2_px0", ppi_data, 16'hACE1);

      for (int c = 0; c < 8000; c++) begin
         step();
         rst   = ($urandom_range(0, 999) == 0);
         start = ($urandom_range(0, 15) == 0);
         stop  = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
         num_frames = 8'($urandom_range(0, 3));
      end

      step();
      rst = 1'b0; start = 1'b0; stop = 1'b1;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_ppi);
         if (ready && !busy) begin
            ok = 1;
            break;
         end
      end
      check("drain_to_idle", ok, 1'b1);
      step();
      stop = 1'b0;
      repeat (4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
